// File: rtl/mips_avalon_pkg.sv
// Shared types and lane helpers for the MIPS-side Avalon-MM master.
// Covers the transaction state, the access-size encodings and the alignment rules.
package mips_avalon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // A request is rejected for an illegal size or when it is not naturally aligned.
  function automatic logic req_error(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return offset[0];
      SIZE_WORD: return offset != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: return 4'b0001 << offset;
      SIZE_HALF: return offset[1] ? 4'b1100 : 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mips_avalon_lane_align.sv
// Little-endian byte-lane steering: store data and enables out, extended load data in.
// Purely combinational; the store path and the load path are independent.
module mips_avalon_lane_align
  import mips_avalon_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_offset,
  input  logic [31:0] st_data,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_offset,
  input  logic        ld_signed,
  input  logic [31:0] readdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    // NOTE: every output gets a value on every path through this block, so no latch is inferred.
    byteenable = lane_enable(st_size, st_offset);
    case (st_size)
      SIZE_BYTE: writedata = {4{st_data[7:0]}};
      SIZE_HALF: writedata = {2{st_data[15:0]}};
      default:   writedata = st_data;
    endcase

    shifted = readdata >> {ld_offset, 3'b000};
    case (ld_size)
      SIZE_BYTE: ld_data = ld_signed ? {{24{shifted[7]}}, shifted[7:0]} : {24'd0, shifted[7:0]};
      SIZE_HALF: ld_data = ld_signed ? {{16{shifted[15]}}, shifted[15:0]} : {16'd0, shifted[15:0]};
      default:   ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/mips_avalon_master.sv
// CPU-side Avalon-MM master: one load/store in, one Avalon read/write out, one response back.
// Holds the bus request through waitrequest, with an optional stall timeout.
module mips_avalon_master
  import mips_avalon_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  state_t      state;
  logic [1:0]  size_q;
  logic [1:0]  offset_q;
  logic        signed_q;
  logic [31:0] wait_cnt;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] ld_data;
  logic        accept;
  logic        acc_err;
  logic        timeout;

  mips_avalon_lane_align u_align (
    .st_size    (req_size),
    .st_offset  (req_addr[1:0]),
    .st_data    (req_wdata),
    .byteenable (lane_be),
    .writedata  (lane_wdata),
    .ld_size    (size_q),
    .ld_offset  (offset_q),
    .ld_signed  (signed_q),
    .readdata   (readdata),
    .ld_data    (ld_data)
  );

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign acc_err   = req_error(req_size, req_addr[1:0]);
  // The stall that would make the count reach MAX_WAIT aborts instead of being counted.
  assign timeout   = (MAX_WAIT != 0) && (wait_cnt == MAX_WAIT - 1);

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      size_q     <= SIZE_BYTE;
      offset_q   <= 2'b00;
      signed_q   <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            wait_cnt <= '0;
            size_q   <= req_size;
            offset_q <= req_addr[1:0];
            signed_q <= req_signed;
            if (acc_err) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state      <= BUS;
              address    <= {req_addr[31:2], 2'b00};
              byteenable <= lane_be;
              writedata  <= lane_wdata;
              write      <= req_write;
              read       <= !req_write;
            end
          end
        end
        BUS: begin
          if (!waitrequest) begin
            state     <= RESP;
            read      <= 1'b0;
            write     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= read ? ld_data : '0;
          end else if (timeout) begin
            state     <= RESP;
            read      <= 1'b0;
            write     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else if (MAX_WAIT != 0) begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
